// File: rtl/serial_ripple_adder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_ripple_adder_pkg
//  Description : Shared types and sizing helpers for the serial ripple adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_ripple_adder_pkg;

    // Controller states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to consume a full operand
    function automatic int calc_steps(input int width, input int bpc);
        return (bpc > 0) ? (width / bpc) : 1;
    endfunction

    // Step counter width; never narrower than one bit
    function automatic int calc_cnt_width(input int steps);
        return (steps < 2) ? 1 : $clog2(steps);
    endfunction

endpackage : serial_ripple_adder_pkg
`default_nettype wire

// File: rtl/serial_ripple_adder_fa_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fa_cell
//  Description : Combinational one-bit full adder, the unit of the carry chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    // Propagate term shared by sum and carry
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_ripple_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_ripple_adder
//  Description : Multi-cycle adder, BITS_PER_CYCLE bits per clock, LSB first,
//                valid/ready on both sides, reports carry-out and overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_ripple_adder
    import serial_ripple_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int c_steps = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int c_cnt_w = calc_cnt_width(c_steps);
    localparam int c_acc_w = WIDTH - BITS_PER_CYCLE;

    // Reject illegal parameter combinations at elaboration
    if (WIDTH < 2) begin : g_chk_width
        $error("serial_ripple_adder: WIDTH must be at least 2");
    end
    if ((BITS_PER_CYCLE < 1) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_chk_bpc
        $error("serial_ripple_adder: WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic                    r_carry;
    logic [WIDTH-1:0]        r_sum;
    logic                    r_cout;
    logic                    r_ovf;

    logic                    w_last_step;
    logic [BITS_PER_CYCLE:0] w_c;
    logic [BITS_PER_CYCLE-1:0] w_s;
    logic [WIDTH-1:0]        w_sum_full;

    assign w_last_step = (r_cnt == c_cnt_w'(c_steps - 1));

    // Per-cycle carry chain seeded from the registered carry
    assign w_c[0] = r_carry;
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chain
        fa_cell u_fa (
            .a  (r_a[gi]),
            .b  (r_b[gi]),
            .ci (w_c[gi]),
            .s  (w_s[gi]),
            .co (w_c[gi+1])
        );
    end

    // Partial-sum accumulator: result bits enter from the MSB side. When a
    // single cycle covers the whole operand there is nothing to accumulate.
    if (c_acc_w == 0) begin : g_no_acc
        assign w_sum_full = w_s;
    end else begin : g_acc
        logic [c_acc_w-1:0] r_acc;

        assign w_sum_full = {w_s, r_acc};

        // Shift each cycle's result bits down toward the LSB
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_sum_full[WIDTH-1:BITS_PER_CYCLE];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-step shifting and result registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> BITS_PER_CYCLE;
                    r_b     <= r_b >> BITS_PER_CYCLE;
                    r_carry <= w_c[BITS_PER_CYCLE];
                    if (w_last_step) begin
                        // Top cell of this step is the operand MSB
                        r_sum  <= w_sum_full;
                        r_cout <= w_c[BITS_PER_CYCLE];
                        r_ovf  <= w_c[BITS_PER_CYCLE] ^ w_c[BITS_PER_CYCLE-1];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule : serial_ripple_adder
`default_nettype wire

// File: tb/tb_serial_ripple_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_ripple_adder
//  Description : Self-checking bench: directed 8-bit scenarios plus random
//                16-bit sweeps at three step sizes against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_ripple_adder;

    logic clk;
    int   n_checks;
    int   n_pass;

    // Shared comparison: counts every check, reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // 8-bit, one bit per cycle instance for directed scenarios
    // ------------------------------------------------------------------
    logic       rst_n8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    serial_ripple_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (ovf8)
    );

    // Present operands (called just after a negedge) and return at the negedge after acceptance
    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int guard;
        guard     = 0;
        a8        = av;
        b8        = bv;
        cin8      = cv;
        in_valid8 = 1'b1;
        while (!in_ready8 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    // Count edges from acceptance until out_valid is seen
    task automatic wait8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid8) check("result_timeout", 64'(0), 64'(1));
    endtask

    // Full directed operation with result and latency checks
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        start8(av, bv, cv);
        wait8(lat);
        check({tag, "_lat"}, 64'(lat), 64'(8));
        check({tag, "_sum"}, 64'(sum8), 64'(es));
        check({tag, "_cout"}, 64'(cout8), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf8), 64'(eo));
    endtask

    // ------------------------------------------------------------------
    // 16-bit sweeps at 1, 4 and 16 bits per cycle, random operands
    // ------------------------------------------------------------------
    logic rst_n16;

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 4 : 16);

        logic        iv, ir, ci, ov, ordy, co, ovf, done;
        logic [15:0] av, bv, s;

        serial_ripple_adder #(.WIDTH(16), .BITS_PER_CYCLE(BPC)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n16),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (av),
            .b         (bv),
            .cin       (ci),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (s),
            .cout      (co),
            .overflow  (ovf)
        );

        initial begin
            logic [15:0] ea, eb, esum;
            logic        ec, ecout, eovf;
            logic [16:0] full;
            int          lat, guard, d;
            done = 1'b0;
            iv   = 1'b0;
            ordy = 1'b0;
            av   = '0;
            bv   = '0;
            ci   = 1'b0;
            guard = 0;
            @(negedge clk);
            while (!rst_n16 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            for (int n = 0; n < 1000; n++) begin
                case ($urandom_range(0, 7))
                    0:       ea = 16'hFFFF;
                    1:       ea = 16'h8000;
                    2:       ea = 16'h7FFF;
                    3:       ea = 16'h0000;
                    default: ea = 16'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       eb = 16'hFFFF;
                    1:       eb = 16'h8000;
                    2:       eb = 16'h0001;
                    3:       eb = 16'h0000;
                    default: eb = 16'($urandom);
                endcase
                ec = 1'($urandom_range(0, 1));

                // Reference: plain wide addition, sign rule for overflow
                full  = 17'(ea) + 17'(eb) + 17'(ec);
                esum  = full[15:0];
                ecout = full[16];
                eovf  = (ea[15] == eb[15]) && (esum[15] != ea[15]);

                av = ea;
                bv = eb;
                ci = ec;
                iv = 1'b1;
                guard = 0;
                while (!ir && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 100) check("sweep_accept_timeout", 64'(0), 64'(1));
                @(negedge clk);
                iv  = 1'b0;
                lat = 0;
                while (!ov && lat < 100) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("sweep_bpc%0d_lat", BPC), 64'(lat), 64'(16 / BPC));
                check($sformatf("sweep_bpc%0d_sum a=%h b=%h c=%0d", BPC, ea, eb, ec), 64'(s), 64'(esum));
                check($sformatf("sweep_bpc%0d_cout", BPC), 64'(co), 64'(ecout));
                check($sformatf("sweep_bpc%0d_ovf", BPC), 64'(ovf), 64'(eovf));

                // Random backpressure before draining the result
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                if (d > 0) begin
                    check($sformatf("sweep_bpc%0d_hold_valid", BPC), 64'(ov), 64'(1));
                    check($sformatf("sweep_bpc%0d_hold_sum", BPC), 64'(s), 64'(esum));
                end
                ordy = 1'b1;
                @(negedge clk);
                ordy = 1'b0;
                check($sformatf("sweep_bpc%0d_drained", BPC), 64'(ov), 64'(0));
            end
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence and final summary
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int seen;
        int guard;
        n_checks   = 0;
        n_pass     = 0;
        rst_n8     = 1'b0;
        rst_n16    = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;

        // Reset held for two edges, then released
        @(negedge clk);
        @(negedge clk);
        rst_n8  = 1'b1;
        rst_n16 = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready8), 64'(1));
        check("rst_out_valid", 64'(out_valid8), 64'(0));
        check("rst_sum", 64'(sum8), 64'(0));
        check("rst_cout", 64'(cout8), 64'(0));
        check("rst_ovf", 64'(ovf8), 64'(0));

        // Basic add; out_ready already high so it drains on the first DONE cycle
        op8("basic", 8'h3C, 8'h15, 1'b1, 8'h52, 1'b0, 1'b0);
        @(negedge clk);
        check("basic_in_ready_after", 64'(in_ready8), 64'(1));
        check("basic_out_valid_after", 64'(out_valid8), 64'(0));

        // Wrap-around and signed overflow corners
        op8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        op8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        @(negedge clk);
        op8("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);

        // Backpressure: result held, new operands ignored while DONE
        out_ready8 = 1'b0;
        op8("bp", 8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);
        a8        = 8'h01;
        b8        = 8'h01;
        cin8      = 1'b0;
        in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid8), 64'(1));
            check("bp_hold_sum", 64'(sum8), 64'(8'h77));
            check("bp_hold_in_ready", 64'(in_ready8), 64'(0));
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("bp_drained", 64'(out_valid8), 64'(0));
        op8("bp_next", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        @(negedge clk);

        // Reset at RUN step 3 aborts the operation
        start8(8'hAA, 8'h11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n8 = 1'b0;
        @(negedge clk);
        check("abort_in_ready_low", 64'(in_ready8), 64'(0));
        check("abort_out_valid", 64'(out_valid8), 64'(0));
        rst_n8 = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid8) seen++;
        end
        check("abort_no_result", 64'(seen), 64'(0));
        check("abort_sum", 64'(sum8), 64'(0));
        check("abort_cout", 64'(cout8), 64'(0));
        check("abort_ovf", 64'(ovf8), 64'(0));
        check("abort_in_ready", 64'(in_ready8), 64'(1));
        op8("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        @(negedge clk);

        // Wait for the random sweeps, bounded
        guard = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60000) check("sweep_timeout", 64'(0), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_ripple_adder
`default_nettype wire
